// File: rtl/cla_pipe_alu.sv
// Two-stage pipelined add/sub/accumulate ALU built from 4-bit carry-look-ahead groups.
// Stage 1 resolves the lower half and its carry; stage 2 finishes the upper half and drives the outputs.
module cla_pipe_alu #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic [WIDTH-1:0] acc
);

  localparam int HALF = WIDTH / 2;
  localparam int HPAD = ((HALF + 3) / 4) * 4;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_ACC = 2'b10;
  localparam logic [1:0] OP_CLR = 2'b11;

  // Half-width adder: look-ahead carries inside each 4-bit group, group carry chained to the next.
  // The half is zero-padded to whole groups so any even HALF works.
  function automatic logic [HALF:0] cla_half(input logic [HALF-1:0] x,
                                             input logic [HALF-1:0] y,
                                             input logic            ci);
    logic [HPAD-1:0] xp, yp, g, p;
    logic [HPAD:0]   c;
    logic            t;
    xp = HPAD'(x);
    yp = HPAD'(y);
    g  = xp & yp;
    p  = xp ^ yp;
    c  = '0;
    c[0] = ci;
    for (int base = 0; base < HPAD; base += 4) begin
      for (int j = 1; j <= 4; j++) begin
        t = c[base];
        for (int k = 0; k < j; k++) t = t & p[base+k];
        c[base+j] = t;
        for (int k = 0; k < j; k++) begin
          t = g[base+k];
          for (int m = k + 1; m < j; m++) t = t & p[base+m];
          c[base+j] = c[base+j] | t;
        end
      end
    end
    return {c[HALF], p[HALF-1:0] ^ c[HALF-1:0]};
  endfunction

  logic             run;
  logic             s1_valid;
  logic [1:0]       s1_op;
  logic [HALF-1:0]  s1_sum_lo;
  logic             s1_c_half;
  logic [HALF-1:0]  s1_x_hi;
  logic [HALF-1:0]  s1_y_hi;

  logic [WIDTH-1:0] x_in, y_in;
  logic             c_in;
  logic [HALF:0]    lo_res, hi_res;
  logic [WIDTH-1:0] s2_sum_d;
  logic             s2_cout_d, s2_ovf_d;
  logic             s2_adv, s1_adv, hazard, accept, s1_acc_op;

  always_comb begin
    x_in = '0;
    y_in = '0;
    c_in = 1'b0;
    unique case (op)
      OP_ADD: begin x_in = a;   y_in = b;  c_in = cin;  end
      OP_SUB: begin x_in = a;   y_in = ~b; c_in = 1'b1; end
      OP_ACC: begin x_in = acc; y_in = a;  c_in = cin;  end
      OP_CLR: begin x_in = '0;  y_in = '0; c_in = 1'b0; end
      default: ;
    endcase
  end

  assign lo_res    = cla_half(x_in[HALF-1:0], y_in[HALF-1:0], c_in);
  assign hi_res    = cla_half(s1_x_hi, s1_y_hi, s1_c_half);
  assign s2_sum_d  = {hi_res[HALF-1:0], s1_sum_lo};
  assign s2_cout_d = hi_res[HALF];
  assign s2_ovf_d  = (s1_x_hi[HALF-1] == s1_y_hi[HALF-1]) &&
                     (hi_res[HALF-1] != s1_x_hi[HALF-1]);

  assign s1_acc_op = (s1_op == OP_ACC) || (s1_op == OP_CLR);
  assign s2_adv    = !out_valid || out_ready;
  assign s1_adv    = !s1_valid || s2_adv;
  // An ACC reads acc in stage 1, so it must wait until a preceding ACC/CLR has written it.
  assign hazard    = (op == OP_ACC) && s1_valid && s1_acc_op;
  assign in_ready  = run && s1_adv && !hazard;
  assign accept    = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) run <= 1'b0;
    else        run <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_op     <= OP_ADD;
      s1_sum_lo <= '0;
      s1_c_half <= 1'b0;
      s1_x_hi   <= '0;
      s1_y_hi   <= '0;
    end else if (s1_adv) begin
      s1_valid <= accept;
      if (accept) begin
        s1_op     <= op;
        s1_sum_lo <= lo_res[HALF-1:0];
        s1_c_half <= lo_res[HALF];
        s1_x_hi   <= x_in[WIDTH-1:HALF];
        s1_y_hi   <= y_in[WIDTH-1:HALF];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        sum  <= s2_sum_d;
        cout <= s2_cout_d;
        ovf  <= s2_ovf_d;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          acc <= '0;
    else if (s2_adv && s1_valid && s1_acc_op) acc <= s2_sum_d;
  end

endmodule

// File: tb/tb_cla_pipe_alu.sv
// Scoreboard bench for cla_pipe_alu (WIDTH=16): directed vectors, expected results queued at issue
// and compared by an independent output monitor.
module tb_cla_pipe_alu;

  localparam logic [1:0] ADD = 2'b00, SUB = 2'b01, ACC = 2'b10, CLR = 2'b11;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, cin, out_valid, out_ready, cout, ovf;
  logic [1:0]  op;
  logic [15:0] a, b, sum, acc;

  typedef struct {
    logic [15:0] s;
    logic        c;
    logic        o;
  } exp_t;

  typedef struct {
    logic [1:0]  o;
    logic [15:0] a;
    logic [15:0] b;
    logic        ci;
    logic [15:0] s;
    logic        c;
    logic        v;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[$];
  int   passed = 0;
  int   total  = 0;

  cla_pipe_alu #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .acc(acc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Called at a negedge; returns at the negedge after the acceptance edge.
  task automatic issue(input logic [1:0] o, input logic [15:0] ia, input logic [15:0] ib,
                       input logic ic, input logic [15:0] es, input logic ec, input logic eo,
                       input bit push, output int stalls);
    exp_t e;
    in_valid = 1'b1; op = o; a = ia; b = ib; cin = ic;
    stalls = 0;
    #1;
    while (!in_ready) begin
      if (stalls >= 50) begin
        total++;
        $display("FAIL issue_timeout: in_ready stayed %0b expected 1", in_ready);
        break;
      end
      @(negedge clk);
      stalls++;
      #1;
    end
    if (push) begin
      e.s = es; e.c = ec; e.o = eo;
      exp_q.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    #1;
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL unexpected_output: got sum %0h expected no output", sum);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sum", {16'h0, sum}, {16'h0, e.s});
        chk("cout", {31'h0, cout}, {31'h0, e.c});
        chk("ovf", {31'h0, ovf}, {31'h0, e.o});
      end
    end
  end

  initial begin
    int st, st_sum;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    op = ADD; a = '0; b = '0; cin = 1'b0;
    #2;
    chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_sum", {16'h0, sum}, 32'h0);
    chk("rst_cout_ovf", {30'h0, cout, ovf}, 32'h0);
    chk("rst_acc", {16'h0, acc}, 32'h0);
    chk("rst_in_ready", {31'h0, in_ready}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("in_ready_before_edge", {31'h0, in_ready}, 32'h0);
    @(posedge clk);
    #1 chk("in_ready_after_edge", {31'h0, in_ready}, 32'h1);
    @(negedge clk);

    // Latency: result visible after exactly two edges
    issue(ADD, 16'h0005, 16'h0006, 1'b1, 16'h000C, 1'b0, 1'b0, 1'b1, st);
    #1 chk("latency_1edge", {31'h0, out_valid}, 32'h0);
    @(negedge clk);
    #1 chk("latency_2edge", {31'h0, out_valid}, 32'h1);

    vecs.push_back('{ADD, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0});
    vecs.push_back('{ADD, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1});
    vecs.push_back('{SUB, 16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b1, 1'b0});
    vecs.push_back('{SUB, 16'h0003, 16'h0005, 1'b1, 16'hFFFE, 1'b0, 1'b0});
    vecs.push_back('{SUB, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1});
    vecs.push_back('{ADD, 16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0});
    vecs.push_back('{ADD, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1});
    vecs.push_back('{ADD, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0});
    vecs.push_back('{CLR, 16'hFFFF, 16'hFFFF, 1'b1, 16'h0000, 1'b0, 1'b0});
    @(negedge clk);
    st_sum = 0;
    foreach (vecs[i]) begin
      issue(vecs[i].o, vecs[i].a, vecs[i].b, vecs[i].ci, vecs[i].s, vecs[i].c, vecs[i].v, 1'b1, st);
      st_sum += st;
    end
    chk("stream_no_stall", st_sum, 32'h0);

    // Accumulate chain: each ACC behind an ACC/CLR stalls exactly one cycle
    issue(CLR, 16'h1111, 16'h2222, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, st);
    for (int k = 1; k <= 3; k++) begin
      issue(ACC, 16'h0010, 16'hAAAA, 1'b0, 16'(k * 16), 1'b0, 1'b0, 1'b1, st);
      chk("acc_hazard_stall", st, 32'h1);
    end
    issue(ACC, 16'hFFF0, 16'h0000, 1'b0, 16'h0020, 1'b1, 1'b0, 1'b1, st);
    chk("acc_wrap_stall", st, 32'h1);
    issue(ADD, 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b1, st);
    issue(ACC, 16'h0001, 16'hFFFF, 1'b1, 16'h0022, 1'b0, 1'b0, 1'b1, st);
    chk("acc_after_add_stall", st, 32'h0);
    repeat (3) @(negedge clk);
    #1 chk("acc_final", {16'h0, acc}, 32'h0022);

    // Backpressure: both stages fill, outputs hold, order preserved
    @(negedge clk);
    out_ready = 1'b0;
    issue(ADD, 16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b0, 1'b1, st);
    issue(ADD, 16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0, 1'b1, st);
    in_valid = 1'b1; op = ADD; a = 16'h0005; b = 16'h0006; cin = 1'b0;
    #1 chk("full_in_ready", {31'h0, in_ready}, 32'h0);
    @(negedge clk);
    #1 chk("full_in_ready_hold", {31'h0, in_ready}, 32'h0);
    chk("full_sum_hold", {16'h0, sum}, 32'h0003);
    @(negedge clk);
    out_ready = 1'b1;
    issue(ADD, 16'h0005, 16'h0006, 1'b0, 16'h000B, 1'b0, 1'b0, 1'b1, st);
    issue(ADD, 16'h0007, 16'h0008, 1'b0, 16'h000F, 1'b0, 1'b0, 1'b1, st);
    repeat (4) @(negedge clk);
    chk("drain_empty", exp_q.size(), 32'h0);

    // Reset with two operations in flight
    out_ready = 1'b0;
    issue(ADD, 16'h0009, 16'h0009, 1'b0, 16'h0012, 1'b0, 1'b0, 1'b0, st);
    issue(ACC, 16'h0001, 16'h0001, 1'b0, 16'h0023, 1'b0, 1'b0, 1'b0, st);
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("mid_rst_acc", {16'h0, acc}, 32'h0);
    chk("mid_rst_in_ready", {31'h0, in_ready}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (6) @(negedge clk);
    #1;
    chk("post_rst_no_output", {31'h0, out_valid}, 32'h0);
    chk("post_rst_in_ready", {31'h0, in_ready}, 32'h1);
    chk("final_queue_empty", exp_q.size(), 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: time %0t expected finish", $time);
    $fatal(1);
  end

endmodule
